mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 37 +++
 rtl/mem_arb.sv | 108 ++++++++++
 tb/tb_mem_arb.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared widths, state encodings and request payload for the memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_BUS      = 64;
  localparam int unsigned DATA_ADDR_BUS = 64;
  localparam int unsigned SIZE_W        = 2;
  localparam int unsigned RESP_W        = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_INST = 2'b01,
    ARB_DATA = 2'b10
  } arb_state_e;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_e;

  typedef struct packed {
    logic                     valid;
    logic [DATA_BUS-1:0]      wdata;
    logic [DATA_ADDR_BUS-1:0] addr;
    logic [SIZE_W-1:0]        size;
    logic                     we;
  } mem_cmd_t;

  // Ties go to whichever requester was not served most recently.
  function automatic arb_state_e pick_grant(input logic inst_v, input logic data_v,
                                            input grant_e last);
    if (inst_v && data_v) return (last == GRANT_DATA) ? ARB_INST : ARB_DATA;
    if (inst_v)           return ARB_INST;
    if (data_v)           return ARB_DATA;
    return ARB_IDLE;
  endfunction

endpackage

// File: rtl/mem_arb.sv
// Two-requester (fetch / load-store) arbiter onto a single downstream memory port.
module mem_arb
  import mem_arb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     inst_valid,
  output logic                     inst_ready,
  output logic [DATA_BUS-1:0]      inst_data_read,
  input  logic [DATA_ADDR_BUS-1:0] inst_addr,
  input  logic [SIZE_W-1:0]        inst_size,
  output logic [RESP_W-1:0]        inst_resp,

  input  logic                     data_valid,
  output logic                     data_ready,
  output logic [DATA_BUS-1:0]      data_data_read,
  input  logic [DATA_BUS-1:0]      data_data_write,
  input  logic [DATA_ADDR_BUS-1:0] data_addr,
  input  logic [SIZE_W-1:0]        data_size,
  output logic [RESP_W-1:0]        data_resp,
  input  logic                     data_req,

  output logic                     mem_valid,
  output logic [DATA_BUS-1:0]      mem_data_write,
  output logic [DATA_ADDR_BUS-1:0] mem_addr,
  output logic [SIZE_W-1:0]        mem_size,
  output logic                     mem_req,
  input  logic                     mem_ready,
  input  logic [DATA_BUS-1:0]      mem_data_read,
  input  logic [RESP_W-1:0]        mem_resp
);

  arb_state_e state_q, state_d;
  grant_e     last_grant_q, last_grant_d;
  mem_cmd_t   cmd;

  // Next-state: grant from idle, hold until the downstream completes.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: state_d = pick_grant(inst_valid, data_valid, last_grant_q);
      ARB_INST: begin
        if (mem_ready) begin
          state_d      = ARB_IDLE;
          last_grant_d = GRANT_INST;
        end
      end
      ARB_DATA: begin
        if (mem_ready) begin
          state_d      = ARB_IDLE;
          last_grant_d = GRANT_DATA;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_DATA;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Request steering and response return; the non-granted side sees zeros.
  always_comb begin
    cmd            = '0;
    inst_ready     = 1'b0;
    inst_data_read = '0;
    inst_resp      = '0;
    data_ready     = 1'b0;
    data_data_read = '0;
    data_resp      = '0;
    case (state_q)
      ARB_INST: begin
        cmd.valid      = inst_valid;
        cmd.addr       = inst_addr;
        cmd.size       = inst_size;
        inst_ready     = mem_ready;
        inst_data_read = mem_data_read;
        inst_resp      = mem_resp;
      end
      ARB_DATA: begin
        cmd.valid      = data_valid;
        cmd.wdata      = data_data_write;
        cmd.addr       = data_addr;
        cmd.size       = data_size;
        cmd.we         = data_req;
        data_ready     = mem_ready;
        data_data_read = mem_data_read;
        data_resp      = mem_resp;
      end
      default: ;
    endcase
  end

  assign mem_valid      = cmd.valid;
  assign mem_data_write = cmd.wdata;
  assign mem_addr       = cmd.addr;
  assign mem_size       = cmd.size;
  assign mem_req        = cmd.we;

endmodule

// File: tb/tb_mem_arb.sv
// Directed scenarios plus a randomized run checked against a transaction-level arbitration model.
module tb_mem_arb;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [63:0] inst_data_read;
  logic [63:0] inst_addr;
  logic [1:0]  inst_size;
  logic [1:0]  inst_resp;
  logic        data_valid;
  logic        data_ready;
  logic [63:0] data_data_read;
  logic [63:0] data_data_write;
  logic [63:0] data_addr;
  logic [1:0]  data_size;
  logic [1:0]  data_resp;
  logic        data_req;
  logic        mem_valid;
  logic [63:0] mem_data_write;
  logic [63:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_req;
  logic        mem_ready;
  logic [63:0] mem_data_read;
  logic [1:0]  mem_resp;

  int errors = 0;
  int checks = 0;

  mem_arb dut (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data_read(inst_data_read),
    .inst_addr(inst_addr), .inst_size(inst_size), .inst_resp(inst_resp),
    .data_valid(data_valid), .data_ready(data_ready), .data_data_read(data_data_read),
    .data_data_write(data_data_write), .data_addr(data_addr), .data_size(data_size),
    .data_resp(data_resp), .data_req(data_req),
    .mem_valid(mem_valid), .mem_data_write(mem_data_write), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_req(mem_req), .mem_ready(mem_ready),
    .mem_data_read(mem_data_read), .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_valid"}, 64'(mem_valid), 64'd0);
    chk({tag, " mem_addr"}, mem_addr, 64'd0);
    chk({tag, " mem_wdata"}, mem_data_write, 64'd0);
    chk({tag, " mem_size"}, 64'(mem_size), 64'd0);
    chk({tag, " mem_req"}, 64'(mem_req), 64'd0);
    chk({tag, " inst_ready"}, 64'(inst_ready), 64'd0);
    chk({tag, " inst_rdata"}, inst_data_read, 64'd0);
    chk({tag, " inst_resp"}, 64'(inst_resp), 64'd0);
    chk({tag, " data_ready"}, 64'(data_ready), 64'd0);
    chk({tag, " data_rdata"}, data_data_read, 64'd0);
    chk({tag, " data_resp"}, 64'(data_resp), 64'd0);
  endtask

  task automatic clear_inputs();
    inst_valid = 0; inst_addr = '0; inst_size = '0;
    data_valid = 0; data_addr = '0; data_size = '0; data_data_write = '0; data_req = 0;
    mem_ready = 0; mem_data_read = '0; mem_resp = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Transaction-level model state for the random phase: 0 none, 1 inst, 2 data
  int owner, last_srv, lat, n_done, n_inst, n_data;
  bit ip, dp;

  initial begin
    rst = 1'b1;
    clear_inputs();
    do_reset();
    #1 chk_all_zero("reset");

    // Spurious mem_ready while idle must produce nothing
    @(negedge clk); mem_ready = 1; mem_data_read = 64'h77; mem_resp = 2'b11;
    #1 chk_all_zero("idle_ready0");
    @(negedge clk);
    #1 chk_all_zero("idle_ready1");
    @(negedge clk); mem_ready = 0; inst_valid = 1; inst_addr = 64'h4000; inst_size = 2'd3;
    #1 chk("idle_stay mem_valid", 64'(mem_valid), 64'd0);
    @(negedge clk);
    #1 chk("idle_then_grant mem_valid", 64'(mem_valid), 64'd1);
    do_reset();

    // Single fetch, completion on third grant cycle
    @(negedge clk); inst_valid = 1; inst_addr = 64'h8000_0000; inst_size = 2'd2;
    #1 chk("fetch c0 mem_valid", 64'(mem_valid), 64'd0);
    @(negedge clk);
    #1 chk("fetch c1 mem_valid", 64'(mem_valid), 64'd1);
    chk("fetch c1 mem_addr", mem_addr, 64'h8000_0000);
    chk("fetch c1 mem_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    #1 chk("fetch c2 inst_ready", 64'(inst_ready), 64'd0);
    @(negedge clk); mem_ready = 1; mem_data_read = 64'h13;
    #1 chk("fetch c3 inst_ready", 64'(inst_ready), 64'd1);
    chk("fetch c3 inst_rdata", inst_data_read, 64'h13);
    chk("fetch c3 data_ready", 64'(data_ready), 64'd0);
    @(negedge clk); inst_valid = 0; mem_ready = 0;
    #1 chk("fetch done mem_valid", 64'(mem_valid), 64'd0);
    chk("fetch done inst_ready", 64'(inst_ready), 64'd0);

    // Reset in the middle of a data grant; last served was INST
    @(negedge clk); data_valid = 1; data_addr = 64'h1234; data_req = 0; data_size = 2'd1;
    #1 chk("rstmid c0 mem_valid", 64'(mem_valid), 64'd0);
    @(negedge clk);
    #1 chk("rstmid grant mem_addr", mem_addr, 64'h1234);
    chk("rstmid grant mem_valid", 64'(mem_valid), 64'd1);
    rst = 1;
    @(negedge clk); inst_valid = 1; mem_ready = 1; mem_data_read = 64'h55; mem_resp = 2'b01;
    #1 chk_all_zero("rstmid after");
    rst = 0; mem_ready = 0;
    @(negedge clk);
    #1 chk("rstmid tie mem_addr", mem_addr, 64'h8000_0000);
    chk("rstmid tie mem_req", 64'(mem_req), 64'd0);
    do_reset();

    // Simultaneous requests after reset: INST then DATA
    @(negedge clk);
    inst_valid = 1; inst_addr = 64'h8000_0040; inst_size = 2'd2;
    data_valid = 1; data_addr = 64'h8000_1000; data_req = 1; data_data_write = 64'hDEAD_BEEF; data_size = 2'd3;
    #1 chk("tie idle mem_valid", 64'(mem_valid), 64'd0);
    @(negedge clk); mem_ready = 1; mem_data_read = 64'h99;
    #1 chk("tie first mem_addr", mem_addr, 64'h8000_0040);
    chk("tie first inst_ready", 64'(inst_ready), 64'd1);
    chk("tie first data_ready", 64'(data_ready), 64'd0);
    @(negedge clk); inst_valid = 0; mem_ready = 0;
    #1 chk("tie bubble mem_valid", 64'(mem_valid), 64'd0);
    @(negedge clk); mem_ready = 1;
    #1 chk("tie second mem_addr", mem_addr, 64'h8000_1000);
    chk("tie second mem_req", 64'(mem_req), 64'd1);
    chk("tie second mem_wdata", mem_data_write, 64'hDEAD_BEEF);
    chk("tie second mem_size", 64'(mem_size), 64'd3);
    chk("tie second data_ready", 64'(data_ready), 64'd1);
    chk("tie second inst_ready", 64'(inst_ready), 64'd0);
    @(negedge clk); data_valid = 0; mem_ready = 0;

    // Data read carrying an error response
    @(negedge clk); data_valid = 1; data_req = 0; data_addr = 64'h2000;
    @(negedge clk); mem_ready = 1; mem_resp = 2'b10; mem_data_read = 64'hABCD;
    #1 chk("resp data_resp", 64'(data_resp), 64'd2);
    chk("resp data_ready", 64'(data_ready), 64'd1);
    chk("resp data_rdata", data_data_read, 64'hABCD);
    chk("resp inst_resp", 64'(inst_resp), 64'd0);
    @(negedge clk); data_valid = 0; mem_ready = 0; mem_resp = 0;
    do_reset();

    // Both valid continuously: alternating grants with an idle cycle between
    @(negedge clk);
    inst_valid = 1; inst_addr = 64'hA000; data_valid = 1; data_addr = 64'hD000;
    for (int k = 0; k < 6; k++) begin
      mem_ready = 0;
      #1 chk($sformatf("alt%0d bubble", k), 64'(mem_valid), 64'd0);
      @(negedge clk); mem_ready = 1;
      #1 chk($sformatf("alt%0d addr", k), mem_addr, (k % 2 == 0) ? 64'hA000 : 64'hD000);
      chk($sformatf("alt%0d inst_ready", k), 64'(inst_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
      chk($sformatf("alt%0d data_ready", k), 64'(data_ready), (k % 2 == 0) ? 64'd0 : 64'd1);
      @(negedge clk);
    end
    do_reset();

    // Randomized traffic against the arbitration rules
    owner = 0; last_srv = 2; lat = 0; n_done = 0; n_inst = 0; n_data = 0; ip = 0; dp = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; inst_addr = {$urandom, $urandom}; inst_size = 2'($urandom);
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; data_addr = {$urandom, $urandom}; data_data_write = {$urandom, $urandom};
        data_size = 2'($urandom); data_req = 1'($urandom);
      end
      inst_valid = ip; data_valid = dp;
      mem_data_read = {$urandom, $urandom}; mem_resp = 2'($urandom);
      if (owner == 0) mem_ready = ($urandom_range(0, 3) == 0);
      else if (lat == 0) mem_ready = 1;
      else begin mem_ready = 0; lat--; end
      #1;
      if (owner == 0) begin
        chk("rnd idle mem_valid", 64'(mem_valid), 64'd0);
        chk("rnd idle inst_ready", 64'(inst_ready), 64'd0);
        chk("rnd idle data_ready", 64'(data_ready), 64'd0);
      end else if (owner == 1) begin
        chk("rnd inst mem_valid", 64'(mem_valid), 64'd1);
        chk("rnd inst mem_addr", mem_addr, inst_addr);
        chk("rnd inst mem_size", 64'(mem_size), 64'(inst_size));
        chk("rnd inst mem_req", 64'(mem_req), 64'd0);
        chk("rnd inst mem_wdata", mem_data_write, 64'd0);
        chk("rnd inst ready", 64'(inst_ready), 64'(mem_ready));
        chk("rnd inst rdata", inst_data_read, mem_data_read);
        chk("rnd inst resp", 64'(inst_resp), 64'(mem_resp));
        chk("rnd inst data_ready", 64'(data_ready), 64'd0);
        chk("rnd inst data_rdata", data_data_read, 64'd0);
      end else begin
        chk("rnd data mem_valid", 64'(mem_valid), 64'd1);
        chk("rnd data mem_addr", mem_addr, data_addr);
        chk("rnd data mem_size", 64'(mem_size), 64'(data_size));
        chk("rnd data mem_req", 64'(mem_req), 64'(data_req));
        chk("rnd data mem_wdata", mem_data_write, data_data_write);
        chk("rnd data ready", 64'(data_ready), 64'(mem_ready));
        chk("rnd data rdata", data_data_read, mem_data_read);
        chk("rnd data resp", 64'(data_resp), 64'(mem_resp));
        chk("rnd data inst_ready", 64'(inst_ready), 64'd0);
        chk("rnd data inst_rdata", inst_data_read, 64'd0);
      end
      if (owner != 0 && mem_ready) begin
        if (owner == 1) begin ip = 0; n_inst++; end
        else begin dp = 0; n_data++; end
        last_srv = owner; owner = 0; n_done++;
      end else if (owner == 0) begin
        if (ip && dp) owner = (last_srv == 2) ? 1 : 2;
        else if (ip)  owner = 1;
        else if (dp)  owner = 2;
        if (owner != 0) lat = $urandom_range(0, 3);
      end
    end
    chk("rnd traffic both served", 64'((n_inst > 50) && (n_data > 50)), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
